// File: rtl/regfile_context_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_context_engine_if
// Description : Control, register-file and stream signals of the context engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_context_engine_if #(
    parameter int WIDTH        = 16,
    parameter int SELECT_WIDTH = 4
);
    logic                    save_req;
    logic                    restore_req;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic [SELECT_WIDTH-1:0] rf_raddr;
    logic [WIDTH-1:0]        rf_rdata;
    logic                    rf_write;
    logic [SELECT_WIDTH-1:0] rf_waddr;
    logic [WIDTH-1:0]        rf_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;

    modport slave (
        input  save_req, restore_req, abort, rf_rdata, out_ready, in_valid, in_data,
        output busy, done, aborted, rf_raddr, rf_write, rf_waddr, rf_wdata,
               out_valid, out_data, in_ready
    );

    modport master (
        output save_req, restore_req, abort, rf_rdata, out_ready, in_valid, in_data,
        input  busy, done, aborted, rf_raddr, rf_write, rf_waddr, rf_wdata,
               out_valid, out_data, in_ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_context_engine.sv
`default_nettype none
// ============================================================================
// Module      : regfile_context_engine
// Description : Streams the whole register file out (save) or in (restore).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_context_engine #(
    parameter int WIDTH        = 16,
    parameter int SELECT_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    regfile_context_engine_if.slave    bus
);

    localparam logic [SELECT_WIDTH-1:0] c_last_idx = {SELECT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAVE    = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SELECT_WIDTH-1:0] r_idx;
    logic [SELECT_WIDTH-1:0] w_idx_next;
    logic                    r_aborted;
    logic                    w_abort_pulse;
    logic [WIDTH-1:0]        w_save_word;
    logic [WIDTH-1:0]        w_restore_word;

    assign w_save_word    = bus.rf_rdata;
    assign w_restore_word = bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_aborted <= w_abort_pulse;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_abort_pulse = 1'b0;
        bus.out_valid = 1'b0;
        bus.in_ready  = 1'b0;
        bus.rf_write  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.save_req) begin
                    w_state_next = S_SAVE;
                    w_idx_next   = '0;
                end else if (bus.restore_req) begin
                    w_state_next = S_RESTORE;
                    w_idx_next   = '0;
                end
            end
            S_SAVE: begin
                // Abort kills the beat in the same cycle so no word is half-delivered.
                if (bus.abort) begin
                    w_state_next  = S_IDLE;
                    w_abort_pulse = 1'b1;
                end else begin
                    bus.out_valid = 1'b1;
                    if (bus.out_ready) begin
                        w_idx_next = r_idx + 1'b1;
                        if (r_idx == c_last_idx) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
            end
            S_RESTORE: begin
                if (bus.abort) begin
                    w_state_next  = S_IDLE;
                    w_abort_pulse = 1'b1;
                end else begin
                    bus.in_ready = 1'b1;
                    bus.rf_write = bus.in_valid;
                    if (bus.in_valid) begin
                        w_idx_next = r_idx + 1'b1;
                        if (r_idx == c_last_idx) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.aborted  = r_aborted;
    assign bus.rf_raddr = r_idx;
    assign bus.rf_waddr = r_idx;
    assign bus.rf_wdata = w_restore_word;
    assign bus.out_data = w_save_word;

endmodule
`default_nettype wire
